// File: rtl/ret_stack_spill_if.sv
// ret_stack_spill_if: request, return and data-memory signals of the
// return-address stack.
// slave  = the stack itself.
// master = the surrounding control path plus the memory arbiter.
interface ret_stack_spill_if #(
  parameter int D  = 12,
  parameter int AW = 8
);
  logic          call;
  logic          ret;
  logic [D-1:0]  addr;
  logic          stall;
  logic          ret_valid;
  logic [D-1:0]  ret_target;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [D-1:0]  mem_wdata;
  logic [D-1:0]  mem_rdata;
  logic          mem_ack;
  logic          err_overflow;
  logic          err_underflow;

  modport slave (
    input  call, ret, addr, mem_rdata, mem_ack,
    output stall, ret_valid, ret_target, mem_req, mem_we, mem_addr, mem_wdata,
           err_overflow, err_underflow
  );

  modport master (
    output call, ret, addr, mem_rdata, mem_ack,
    input  stall, ret_valid, ret_target, mem_req, mem_we, mem_addr, mem_wdata,
           err_overflow, err_underflow
  );
endinterface

// File: rtl/ret_stack_spill.sv
// ret_stack_spill: return-address stack kept in an on-chip circular buffer.
// Define RAS_SPILL_EN to spill the oldest entry to data memory on overflow
// and fill it back on underflow. Without it, the block is a plain stack:
// overflow overwrites the oldest entry, and the memory port and stall are
// tied low.
module ret_stack_spill #(
  parameter int            D           = 12,
  parameter int            STACK_DEPTH = 8,
  parameter int            AW          = 8,
  parameter logic [AW-1:0] MEM_BASE    = 8'hE0,
  parameter int            SPILL_MAX   = 32
) (
  input logic              clk,
  input logic              reset,
  ret_stack_spill_if.slave bus
);
  localparam int PW = $clog2(STACK_DEPTH);
  localparam int CW = PW + 1;

  // top_q is the next free slot; the newest entry sits just below it and the
  // oldest entry is cnt_q slots below it (modulo the depth).
  logic [D-1:0]  stk_q [STACK_DEPTH];
  logic [PW-1:0] top_q, top_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_unf_q, err_unf_d;

  logic          wr_en;
  logic [D-1:0]  wr_data;
  logic          full, empty;
  logic [D-1:0]  top_entry;

  logic          stall_c;
  logic          rv_c;
  logic [D-1:0]  rt_c;

  assign full      = (cnt_q == CW'(STACK_DEPTH));
  assign empty     = (cnt_q == '0);
  assign top_entry = stk_q[top_q - 1'b1];

`ifdef RAS_SPILL_EN
  localparam int SW = $clog2(SPILL_MAX + 1);

  typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [D-1:0]  mem_wdata_q, mem_wdata_d;
  logic [D-1:0]  old_entry;
  logic          ack;
  logic          spill_room;

  assign old_entry  = stk_q[top_q - PW'(cnt_q)];
  assign ack        = bus.mem_ack & mem_req_q;
  assign spill_room = (scnt_q != SW'(SPILL_MAX));

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
`else
  logic unused_in;
  assign unused_in = ^{bus.mem_rdata, bus.mem_ack, MEM_BASE, SPILL_MAX};

  assign bus.mem_req   = 1'b0;
  assign bus.mem_we    = 1'b0;
  assign bus.mem_addr  = '0;
  assign bus.mem_wdata = '0;
`endif

  assign bus.stall         = stall_c;
  assign bus.ret_valid     = rv_c;
  assign bus.ret_target    = rt_c;
  assign bus.err_overflow  = err_ovf_q;
  assign bus.err_underflow = err_unf_q;

  // Next-state logic: push/pop in IDLE, memory transaction tracking otherwise.
  // The IDLE push/pop chain is shared by both builds; with spill enabled it
  // becomes the final else-branch after the SPILL/FILL handling.
  always_comb begin
    top_d     = top_q;
    cnt_d     = cnt_q;
    err_ovf_d = err_ovf_q;
    err_unf_d = err_unf_q;
    wr_en     = 1'b0;
    wr_data   = bus.addr + 1'b1;
    stall_c   = 1'b0;
    rv_c      = 1'b0;
    rt_c      = '0;
`ifdef RAS_SPILL_EN
    state_d     = state_q;
    scnt_d      = scnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_q == SPILL) begin
      stall_c = 1'b1;
      if (ack) begin
        scnt_d    = scnt_q + 1'b1;
        cnt_d     = cnt_q - 1'b1;
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    end else if (state_q == FILL) begin
      stall_c = ~ack;
      if (ack) begin
        rv_c      = 1'b1;
        rt_c      = bus.mem_rdata;
        scnt_d    = scnt_q - 1'b1;
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    end else
`endif
    if (bus.call) begin
`ifdef RAS_SPILL_EN
      if (full && spill_room) begin
        stall_c     = 1'b1;
        state_d     = SPILL;
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = MEM_BASE + AW'(scnt_q);
        mem_wdata_d = old_entry;
      end else
`endif
      begin
        // When full, writing at top lands on the oldest slot: an overwrite.
        wr_en = 1'b1;
        top_d = top_q + 1'b1;
        if (full) begin
          err_ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end else if (bus.ret) begin
      if (!empty) begin
        rv_c  = 1'b1;
        rt_c  = top_entry;
        top_d = top_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
`ifdef RAS_SPILL_EN
      else if (scnt_q != '0) begin
        stall_c    = 1'b1;
        state_d    = FILL;
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b0;
        mem_addr_d = MEM_BASE + AW'(scnt_q) - 1'b1;
      end
`endif
      else begin
        err_unf_d = 1'b1;
      end
    end
  end

  // State, buffer and registered memory-port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
      top_q     <= '0;
      cnt_q     <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
`ifdef RAS_SPILL_EN
      state_q     <= IDLE;
      scnt_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`endif
    end else begin
      if (wr_en) stk_q[top_q] <= wr_data;
      top_q     <= top_d;
      cnt_q     <= cnt_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
`ifdef RAS_SPILL_EN
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`endif
    end
  end
endmodule

// File: tb/tb_ret_stack_spill.sv
// tb_ret_stack_spill: directed bench for ret_stack_spill with a queue-based
// reference model checked every cycle. Expectations follow RAS_SPILL_EN.
module tb_ret_stack_spill;
  localparam int            D     = 12;
  localparam int            DEPTH = 4;
  localparam int            AW    = 8;
  localparam logic [AW-1:0] BASE  = 8'hE0;

`ifdef RAS_SPILL_EN
  localparam int SMAX            = 2;
  localparam int EXP_SPILL_STALL = 4;
  localparam int EXP_SPILL_OVF   = 0;
  localparam int EXP_MEM_B       = 'h101;
  localparam int EXP_FILL_STALL  = 3;
  localparam int EXP_FIFTH_RV    = 1;
  localparam int EXP_FIFTH_RT    = 'h101;
  localparam int EXP_FIFTH_UNF   = 0;
  localparam int EXP_OVF6        = 0;
  localparam int EXP_MEM_E0      = 'h301;
  localparam int EXP_MEM_E1      = 'h302;
  localparam int EXP_SAW_REQ     = 1;
`else
  localparam int SMAX            = 0;
  localparam int EXP_SPILL_STALL = 0;
  localparam int EXP_SPILL_OVF   = 1;
  localparam int EXP_MEM_B       = 0;
  localparam int EXP_FILL_STALL  = 0;
  localparam int EXP_FIFTH_RV    = 0;
  localparam int EXP_FIFTH_RT    = 0;
  localparam int EXP_FIFTH_UNF   = 1;
  localparam int EXP_OVF6        = 1;
  localparam int EXP_MEM_E0      = 0;
  localparam int EXP_MEM_E1      = 0;
  localparam int EXP_SAW_REQ     = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic ack_resp = 1'b0;
  logic ack_stray;
  logic [D-1:0] rdata_r = '0;
  logic [D-1:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  ret_stack_spill_if #(.D(D), .AW(AW)) bus ();

  assign bus.mem_ack   = ack_resp | ack_stray;
  assign bus.mem_rdata = rdata_r;

  ret_stack_spill #(
    .D(D), .STACK_DEPTH(DEPTH), .AW(AW), .MEM_BASE(BASE), .SPILL_MAX(2)
  ) dut (
    .clk(clk),
    .reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Memory: acks on the third cycle mem_req is seen high (2 cycles after it rises).
  initial begin
    int age;
    age = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !bus.mem_req) begin
        age      = 0;
        ack_resp = 1'b0;
      end else begin
        age++;
        if (age == 3) begin
          ack_resp = 1'b1;
          if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
          rdata_r = mem[bus.mem_addr];
        end else begin
          ack_resp = 1'b0;
        end
      end
    end
  end

  // Reference model: on-chip entries (oldest first), spilled entries
  // (bottom first), and the kind of memory transaction outstanding.
  logic [D-1:0] mq [$];
  logic [D-1:0] msp [$];
  int mbusy = 0;   // 0 none, 1 spill, 2 fill
  bit movf = 1'b0;
  bit munf = 1'b0;

  always @(negedge clk) begin
    bit e_stall, e_rv, chk_rt, ack;
    logic [D-1:0] e_rt, pv;
    logic [AW-1:0] ea;
    if (rst) begin
      check("rst_stall", bus.stall, 0);
      check("rst_ret_valid", bus.ret_valid, 0);
      check("rst_ret_target", bus.ret_target, 0);
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_err_overflow", bus.err_overflow, 0);
      check("rst_err_underflow", bus.err_underflow, 0);
      mq.delete();
      msp.delete();
      mbusy = 0;
      movf  = 1'b0;
      munf  = 1'b0;
    end else begin
      e_stall = 1'b0;
      e_rv    = 1'b0;
      chk_rt  = 1'b0;
      e_rt    = '0;
      pv      = bus.addr + 12'd1;
      ack     = bus.mem_ack && (mbusy != 0);
      check("m_err_overflow", bus.err_overflow, movf);
      check("m_err_underflow", bus.err_underflow, munf);
      check("m_mem_req", bus.mem_req, mbusy != 0);
      if (mbusy == 1) begin
        ea = BASE + AW'(msp.size());
        check("m_spill_we", bus.mem_we, 1);
        check("m_spill_addr", bus.mem_addr, ea);
        check("m_spill_wdata", bus.mem_wdata, mq[0]);
      end else if (mbusy == 2) begin
        ea = BASE + AW'(msp.size()) - 8'd1;
        check("m_fill_we", bus.mem_we, 0);
        check("m_fill_addr", bus.mem_addr, ea);
      end

      if (mbusy == 1) begin
        e_stall = 1'b1;
        if (ack) begin
          msp.push_back(mq.pop_front());
          mbusy = 0;
        end
      end else if (mbusy == 2) begin
        e_stall = !ack;
        if (ack) begin
          e_rv   = 1'b1;
          chk_rt = 1'b1;
          e_rt   = msp.pop_back();
          mbusy  = 0;
        end
      end else if (bus.call) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(pv);
        end else if (msp.size() < SMAX) begin
          e_stall = 1'b1;
          mbusy   = 1;
        end else begin
          void'(mq.pop_front());
          mq.push_back(pv);
          movf = 1'b1;
        end
      end else if (bus.ret) begin
        chk_rt = 1'b1;
        if (mq.size() > 0) begin
          e_rv = 1'b1;
          e_rt = mq.pop_back();
        end else if (msp.size() > 0) begin
          e_stall = 1'b1;
          chk_rt  = 1'b0;
          mbusy   = 2;
        end else begin
          munf = 1'b1;
        end
      end
      check("m_stall", bus.stall, e_stall);
      check("m_ret_valid", bus.ret_valid, e_rv);
      if (chk_rt) check("m_ret_target", bus.ret_target, e_rt);
    end
  end

  // One request, held while stall is high; returns stall cycles and pop result.
  task automatic op(input bit c, input bit r, input logic [D-1:0] a,
                    output int stalls, output bit rv, output logic [D-1:0] rt);
    bus.call = c;
    bus.ret  = r;
    bus.addr = a;
    stalls   = 0;
    @(negedge clk);
    while (bus.stall && stalls <= 20) begin
      stalls++;
      @(negedge clk);
    end
    check("op_stall_bounded", bus.stall, 0);
    rv = bus.ret_valid;
    rt = bus.ret_target;
    @(posedge clk);
    #1;
    bus.call = 1'b0;
    bus.ret  = 1'b0;
  endtask

  task automatic push(input logic [D-1:0] a);
    int st; bit rv; logic [D-1:0] rt;
    op(1'b1, 1'b0, a, st, rv, rt);
  endtask

  task automatic pop_expect(input string name, input logic [D-1:0] exp);
    int st; bit rv; logic [D-1:0] rt;
    op(1'b0, 1'b1, '0, st, rv, rt);
    check({name, "_valid"}, rv, 1);
    check({name, "_target"}, rt, exp);
    check({name, "_stall"}, st, 0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus.call = 1'b0;
    bus.ret  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int st, tot; bit rv, saw; logic [D-1:0] rt;
    rst       = 1'b1;
    ack_stray = 1'b0;
    bus.call  = 1'b0;
    bus.ret   = 1'b0;
    bus.addr  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", bus.stall, 0);
    check("reset_mem_req", bus.mem_req, 0);
    check("reset_err_overflow", bus.err_overflow, 0);
    rst = 1'b0;

    // Plain push/pop.
    tot = 0;
    foreach (rt[i]) begin end
    for (int i = 1; i <= 3; i++) begin
      op(1'b1, 1'b0, 12'(i * 'h10), st, rv, rt);
      tot += st;
    end
    check("pp_push_stall", tot, 0);
    pop_expect("pp_pop0", 12'h031);
    pop_expect("pp_pop1", 12'h021);
    pop_expect("pp_pop2", 12'h011);

    // Spill on a full stack.
    for (int i = 0; i < 4; i++) push(12'(12'h100 + i));
    op(1'b1, 1'b0, 12'h200, st, rv, rt);
    check("spill_stall_cycles", st, EXP_SPILL_STALL);
    check("spill_mem_e0", mem[8'hE0], EXP_MEM_B);
    check("spill_err_overflow", bus.err_overflow, EXP_SPILL_OVF);

    // Drain, then fill from memory.
    pop_expect("fill_pop0", 12'h201);
    pop_expect("fill_pop1", 12'h104);
    pop_expect("fill_pop2", 12'h103);
    pop_expect("fill_pop3", 12'h102);
    op(1'b0, 1'b1, '0, st, rv, rt);
    check("fill_stall_cycles", st, EXP_FILL_STALL);
    check("fill_valid", rv, EXP_FIFTH_RV);
    check("fill_target", rt, EXP_FIFTH_RT);
    check("fill_err_underflow", bus.err_underflow, EXP_FIFTH_UNF);

    // Overflow past the spill region.
    do_reset();
    for (int i = 0; i < 6; i++) push(12'(12'h300 + i));
    check("ovf_after6", bus.err_overflow, EXP_OVF6);
    op(1'b1, 1'b0, 12'h306, st, rv, rt);
    check("ovf_push7_stall", st, 0);
    check("ovf_after7", bus.err_overflow, 1);
    check("ovf_mem_e0", mem[8'hE0], EXP_MEM_E0);
    check("ovf_mem_e1", mem[8'hE1], EXP_MEM_E1);
    pop_expect("ovf_pop0", 12'h307);
    pop_expect("ovf_pop1", 12'h306);
    pop_expect("ovf_pop2", 12'h305);
    pop_expect("ovf_pop3", 12'h304);
    for (int i = 0; i < 3; i++) op(1'b0, 1'b1, '0, st, rv, rt);

    // Underflow, stray ack, call/ret priority.
    do_reset();
    ack_stray = 1'b1;
    @(posedge clk);
    #1;
    ack_stray = 1'b0;
    op(1'b0, 1'b1, '0, st, rv, rt);
    check("unf_valid", rv, 0);
    check("unf_target", rt, 0);
    check("unf_flag", bus.err_underflow, 1);
    op(1'b1, 1'b1, 12'h050, st, rv, rt);
    check("prio_valid", rv, 0);
    pop_expect("prio_pop", 12'h051);

    // Reset while a spill is outstanding.
    do_reset();
    for (int i = 0; i < 4; i++) push(12'(12'h400 + i));
    bus.call = 1'b1;
    bus.addr = 12'h404;
    saw = 1'b0;
    for (int i = 0; i < 5 && !saw; i++) begin
      @(negedge clk);
      saw = bus.mem_req;
    end
    check("rmid_saw_req", saw, EXP_SAW_REQ);
    #2;
    rst      = 1'b1;
    bus.call = 1'b0;
    #1;
    check("rmid_mem_req", bus.mem_req, 0);
    check("rmid_stall", bus.stall, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    op(1'b0, 1'b1, '0, st, rv, rt);
    check("rmid_ret_valid", rv, 0);
    check("rmid_err_underflow", bus.err_underflow, 1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: still running at %0t, required finished", $time);
    $fatal(1, "global timeout");
  end
endmodule
